conv_acc_25p: RTL and testbench

//  Consumes the 25 fixed-point products that MulVec_25p emits each cycle for one 5x5 window.

---
 rtl/conv_acc_25p_pkg.sv | 14 +
 rtl/add_tree_25p.sv | 43 ++++
 rtl/conv_acc_25p.sv | 61 ++++++
 tb/tb_conv_acc_25p.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_acc_25p_pkg.sv
// conv_acc_25p_pkg: shared fixed-point defaults and saturation bounds for the conv accumulator
package conv_acc_25p_pkg;
  localparam int FixWidth = 16;
  localparam int FixPoint = 8;
  localparam int AccWidth = 24;
  localparam int Lanes = 25;
  localparam int TreeDepth = 5;
  function automatic longint satHi(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction
  function automatic longint satLo(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction
endpackage

// File: rtl/add_tree_25p.sv
// add_tree_25p: input register plus 5-level registered 25-input adder tree with a travelling valid bit
module add_tree_25p import conv_acc_25p_pkg::*; #(
  parameter int WIDTH = FixWidth,
  parameter int ACC_WIDTH = AccWidth
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        in_valid,
  input  logic [WIDTH*Lanes-1:0]      inP_25P,
  output logic signed [ACC_WIDTH-1:0] sum,
  output logic                        sum_valid
);
  logic signed [ACC_WIDTH-1:0] e0 [Lanes];
  logic signed [ACC_WIDTH-1:0] s1 [13];
  logic signed [ACC_WIDTH-1:0] s2 [7];
  logic signed [ACC_WIDTH-1:0] s3 [4];
  logic signed [ACC_WIDTH-1:0] s4 [2];
  logic [TreeDepth:0] vld;
  assign sum_valid = vld[TreeDepth];
  // Capture sign-extended lanes, then halve the operand count each stage; odd leftovers pass through
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld <= '0;
      sum <= '0;
      for (int i = 0; i < Lanes; i++) e0[i] <= '0;
      for (int i = 0; i < 13; i++) s1[i] <= '0;
      for (int i = 0; i < 7; i++) s2[i] <= '0;
      for (int i = 0; i < 4; i++) s3[i] <= '0;
      for (int i = 0; i < 2; i++) s4[i] <= '0;
    end else begin
      vld <= clear ? '0 : {vld[TreeDepth-1:0], in_valid};
      for (int i = 0; i < Lanes; i++) e0[i] <= ACC_WIDTH'($signed(inP_25P[WIDTH*i +: WIDTH]));
      for (int i = 0; i < 12; i++) s1[i] <= e0[2*i] + e0[2*i+1];
      s1[12] <= e0[24];
      for (int i = 0; i < 6; i++) s2[i] <= s1[2*i] + s1[2*i+1];
      s2[6] <= s1[12];
      for (int i = 0; i < 3; i++) s3[i] <= s2[2*i] + s2[2*i+1];
      s3[3] <= s2[6];
      for (int i = 0; i < 2; i++) s4[i] <= s3[2*i] + s3[2*i+1];
      sum <= s4[0] + s4[1];
    end
endmodule

// File: rtl/conv_acc_25p.sv
// conv_acc_25p: reduces 25 products per vector, accumulates CH_NUM channels, adds bias, ReLU and saturate
module conv_acc_25p import conv_acc_25p_pkg::*; #(
  parameter int WIDTH = FixWidth,
  parameter int POINT_WIDTH = FixPoint,
  parameter int ACC_WIDTH = AccWidth,
  parameter int CH_NUM = 3,
  parameter int CNT_WIDTH = 2,
  parameter int RELU_EN = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic [WIDTH*Lanes-1:0] inP_25P,
  input  logic [WIDTH-1:0]       bias_in,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [CNT_WIDTH-1:0]   ch_cnt
);
  localparam logic signed [ACC_WIDTH-1:0] hiBound = ACC_WIDTH'(satHi(WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] loBound = ACC_WIDTH'(satLo(WIDTH));
  if (2**CNT_WIDTH < CH_NUM || POINT_WIDTH >= WIDTH || ACC_WIDTH < WIDTH + 5 + $clog2(CH_NUM)) begin : gBadParams
    $error("conv_acc_25p: inconsistent parameters");
  end
  logic signed [ACC_WIDTH-1:0] acc, treeSum, total, clipped;
  logic treeValid, lastCh;
  logic [WIDTH-1:0] satData;
  add_tree_25p #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) uTree (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .inP_25P(inP_25P), .sum(treeSum), .sum_valid(treeValid)
  );
  // Final pixel value: running sum plus this channel plus bias, then ReLU and clamp to WIDTH
  always_comb begin
    total = acc + treeSum + ACC_WIDTH'($signed(bias_in));
    clipped = (RELU_EN != 0 && total < 0) ? '0 : total;
    satData = clipped > hiBound ? WIDTH'(hiBound) : clipped < loBound ? WIDTH'(loBound) : clipped[WIDTH-1:0];
    lastCh = ch_cnt == CNT_WIDTH'(CH_NUM - 1);
  end
  // Channel accumulation and pixel emission; clear drops the partial sum but keeps the last pixel
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      ch_cnt <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else if (clear) begin
      acc <= '0;
      ch_cnt <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= treeValid && lastCh;
      if (treeValid && lastCh) begin
        out_data <= satData;
        acc <= '0;
        ch_cnt <= '0;
      end else if (treeValid) begin
        acc <= acc + treeSum;
        ch_cnt <= ch_cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_conv_acc_25p.sv
// tb_conv_acc_25p: scoreboard bench driving three configurations of conv_acc_25p
module tb_conv_acc_25p;
  localparam int W = 16;
  typedef struct { logic [W-1:0] data; int cyc; } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic vA = 1'b0, vB = 1'b0, vC = 1'b0;
  logic [W*25-1:0] vec = '0;
  logic [W-1:0] bias = '0;
  logic ovA, ovB, ovC;
  logic [W-1:0] odA, odB, odC;
  logic chA, chB;
  logic [1:0] chC;
  int cyc = 0, nTests = 0, nFail = 0;
  exp_t sb [3][$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  conv_acc_25p #(.CH_NUM(1), .CNT_WIDTH(1), .RELU_EN(0)) dutA (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(vA), .inP_25P(vec), .bias_in(bias),
    .out_valid(ovA), .out_data(odA), .ch_cnt(chA));
  conv_acc_25p #(.CH_NUM(1), .CNT_WIDTH(1), .RELU_EN(1)) dutB (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(vB), .inP_25P(vec), .bias_in(bias),
    .out_valid(ovB), .out_data(odB), .ch_cnt(chB));
  conv_acc_25p #(.CH_NUM(3), .CNT_WIDTH(2), .RELU_EN(1)) dutC (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(vC), .inP_25P(vec), .bias_in(bias),
    .out_valid(ovC), .out_data(odC), .ch_cnt(chC));

  function automatic logic [W*25-1:0] fill(input logic [W-1:0] lane);
    logic [W*25-1:0] r;
    for (int i = 0; i < 25; i++) r[W*i +: W] = lane;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] m, input logic [W*25-1:0] v, output int at);
    vec = v;
    {vC, vB, vA} = m;
    at = cyc + 1;
    tick();
    {vC, vB, vA} = 3'b000;
  endtask

  task automatic waitEdge(input int n);
    while (cyc < n) tick();
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic pushExp(input int id, input logic [W-1:0] d, input int at);
    exp_t e;
    e.data = d;
    e.cyc = at + 6;
    sb[id].push_back(e);
  endtask

  task automatic monitor(input int id, input logic v, input logic [W-1:0] d);
    exp_t e;
    if (!v) return;
    nTests++;
    if (sb[id].size() == 0) begin
      nFail++;
      $display("FAIL pixel_dut%0d unexpected got=%h at cyc %0d, none required", id, d, cyc);
    end else begin
      e = sb[id].pop_front();
      if (d !== e.data || cyc != e.cyc) begin
        nFail++;
        $display("FAIL pixel_dut%0d got=%h@%0d exp=%h@%0d", id, d, cyc, e.data, e.cyc);
      end
    end
  endtask

  always @(negedge clk)
    if (rst_n) begin
      monitor(0, ovA, odA);
      monitor(1, ovB, odB);
      monitor(2, ovC, odC);
    end

  initial begin
    int at, a0, s, r, m, lv;
    logic [W*25-1:0] rv;
    repeat (2) tick();
    check("reset_out_valid", ovC, 0);
    check("reset_out_data", odC, 0);
    check("reset_ch_cnt", chC, 0);
    rst_n = 1'b1;
    tick();
    // single vector, one channel
    drive(3'b001, fill(16'h0100), at);
    pushExp(0, 16'h1900, at);
    repeat (10) tick();
    // saturation and ReLU on both one-channel configurations
    drive(3'b011, fill(16'h7FFF), at);
    pushExp(0, 16'h7FFF, at);
    pushExp(1, 16'h7FFF, at);
    drive(3'b011, fill(16'h8000), at);
    pushExp(0, 16'h8000, at);
    pushExp(1, 16'h0000, at);
    repeat (8) tick();
    bias = 16'h1A00;
    drive(3'b011, fill(16'hFF00), at);
    pushExp(0, 16'h0100, at);
    pushExp(1, 16'h0100, at);
    repeat (8) tick();
    // three back-to-back channels with bias
    bias = 16'h0080;
    drive(3'b100, fill(16'h0100), a0);
    drive(3'b100, fill(16'h0100), at);
    drive(3'b100, fill(16'h0100), at);
    pushExp(2, 16'h4B80, at);
    waitEdge(a0 + 6);
    check("b2b_cnt1", chC, 1);
    waitEdge(a0 + 7);
    check("b2b_cnt2", chC, 2);
    waitEdge(a0 + 8);
    check("b2b_cnt0", chC, 0);
    check("b2b_pulse_edge8", ovC, 1);
    repeat (4) tick();
    // same with gaps
    drive(3'b100, fill(16'h0100), at);
    repeat (2) tick();
    drive(3'b100, fill(16'h0100), at);
    repeat (3) tick();
    drive(3'b100, fill(16'h0100), at);
    pushExp(2, 16'h4B80, at);
    repeat (10) tick();
    // clear mid-pixel, with a vector presented alongside clear
    bias = 16'h0000;
    drive(3'b100, fill(16'h0100), a0);
    drive(3'b100, fill(16'h0100), at);
    drive(3'b100, fill(16'h0100), at);
    waitEdge(a0 + 6);
    check("clear_pre_cnt", chC, 1);
    clear = 1'b1;
    drive(3'b100, fill(16'h0100), at);
    clear = 1'b0;
    check("clear_cnt", chC, 0);
    repeat (10) tick();
    check("clear_cnt_settled", chC, 0);
    drive(3'b100, fill(16'h0100), at);
    drive(3'b100, fill(16'h0100), at);
    drive(3'b100, fill(16'h0100), at);
    pushExp(2, 16'h4B00, at);
    repeat (10) tick();
    // async reset mid-accumulation
    drive(3'b100, fill(16'h0100), a0);
    drive(3'b100, fill(16'h0100), at);
    waitEdge(a0 + 6);
    check("rst_pre_cnt", chC, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_cnt", chC, 0);
    check("rst_async_valid", ovC, 0);
    check("rst_async_dataC", odC, 0);
    check("rst_async_dataA", odA, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bias = 16'h0080;
    drive(3'b100, fill(16'h0100), at);
    drive(3'b100, fill(16'h0100), at);
    drive(3'b100, fill(16'h0100), at);
    pushExp(2, 16'h4B80, at);
    repeat (10) tick();
    // random streams against a behavioural sum model
    for (int blk = 0; blk < 10; blk++) begin
      m = (blk % 2 != 0) ? 32767 : 600;
      bias = W'($urandom_range(0, 4095) - 2048);
      for (int p = 0; p < 1000; p++) begin
        s = 0;
        for (int ch = 0; ch < 3; ch++) begin
          for (int i = 0; i < 25; i++) begin
            lv = int'($urandom_range(0, 2 * m)) - m;
            rv[W*i +: W] = W'(lv);
            s += lv;
          end
          drive(3'b100, rv, at);
          if ($urandom_range(0, 7) == 0) tick();
        end
        r = s + int'($signed(bias));
        if (r < 0) r = 0;
        if (r > 32767) r = 32767;
        pushExp(2, W'(r), at);
      end
      repeat (10) tick();
    end
    repeat (20) tick();
    for (int id = 0; id < 3; id++) check($sformatf("leftover_dut%0d", id), sb[id].size(), 0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
